// File: rtl/loader_pkg.sv
// loader_pkg: shared states and word-geometry constants for the program loader
package loader_pkg;
  typedef enum logic [2:0] {HDR, LOAD, WRITE, CHK, DONE, ERR} state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_BYTES_LOG2 = 2;
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: byte stream in, instruction-memory write port and boot status out
interface program_loader_if;
  logic [7:0] InData;
  logic InValid;
  logic InReady;
  logic IMWE;
  logic [31:0] IMAddr;
  logic [31:0] IMWData;
  logic CoreRST;
  logic Done;
  logic Error;
  modport master (
    output InData, InValid,
    input InReady, IMWE, IMAddr, IMWData, CoreRST, Done, Error
  );
  modport slave (
    input InData, InValid,
    output InReady, IMWE, IMAddr, IMWData, CoreRST, Done, Error
  );
endinterface

// File: rtl/byte_assembler.sv
// byte_assembler: packs four accepted bytes little-endian into a 32-bit word
module byte_assembler
  import loader_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic Clear,
  input  logic Take,
  input  logic [7:0] InData,
  output logic [31:0] Word,
  output logic WordValid
);
  logic [1:0] cnt;
  logic [23:0] acc;
  assign WordValid = Take && cnt == 2'(BYTES_PER_WORD - 1);
  assign Word = {InData, acc};
  // position each byte by the group counter; the fourth byte goes straight to Word
  always_ff @(posedge CLK) begin
    if (RST || Clear) begin
      cnt <= 2'd0;
      if (RST) acc <= 24'd0;
    end else if (Take) begin
      cnt <= cnt + 2'd1;
      if (!WordValid) acc[{cnt, 3'b000} +: 8] <= InData;
    end
  end
endmodule

// File: rtl/program_loader.sv
// program_loader: writes a length-prefixed, XOR-checked image into instruction memory
module program_loader
  import loader_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic CLK,
  input logic RST,
  program_loader_if.slave bus
);
  localparam int IW = $clog2(DEPTH + 1);
  state_t state;
  logic [31:0] count;
  logic [31:0] sum;
  logic [31:0] word;
  logic [IW-1:0] idx;
  logic accepting;
  logic take;
  logic wv;
  assign accepting = state == HDR || state == LOAD || state == CHK;
  assign bus.InReady = !RST && accepting;
  assign take = bus.InValid && bus.InReady;
  byte_assembler u_asm (
    .CLK(CLK),
    .RST(RST),
    .Clear(!accepting),
    .Take(take),
    .InData(bus.InData),
    .Word(word),
    .WordValid(wv)
  );
  // load sequencer: header, word/write pairs, checksum, then sticky DONE or ERR
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= HDR;
      count <= 32'd0;
      sum <= 32'd0;
      idx <= '0;
      bus.IMWE <= 1'b0;
      bus.IMAddr <= 32'd0;
      bus.IMWData <= 32'd0;
      bus.CoreRST <= 1'b1;
      bus.Done <= 1'b0;
      bus.Error <= 1'b0;
    end else begin
      bus.IMWE <= 1'b0;
      case (state)
        HDR: if (wv) begin
          count <= word;
          state <= word == 32'd0 ? DONE : word > 32'(DEPTH) ? ERR : LOAD;
          bus.Done <= word == 32'd0;
          bus.CoreRST <= word != 32'd0;
          bus.Error <= word > 32'(DEPTH);
        end
        LOAD: if (wv) begin
          bus.IMWE <= 1'b1;
          bus.IMAddr <= BASE_ADDR + (32'(idx) << WORD_BYTES_LOG2);
          bus.IMWData <= word;
          state <= WRITE;
        end
        WRITE: begin
          sum <= sum ^ bus.IMWData;
          idx <= idx + IW'(1);
          state <= 32'(idx) + 32'd1 == count ? CHK : LOAD;
        end
        CHK: if (wv) begin
          state <= word == sum ? DONE : ERR;
          bus.Done <= word == sum;
          bus.CoreRST <= word != sum;
          bus.Error <= word != sum;
        end
        default: ;
      endcase
    end
  end
endmodule
